fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage: issues sequential instruction fetches, tracks in-flight responses and
// buffers returned instructions (with PC and predicted next PC) in an in-order FIFO for decode.
module fetch_queue #(
  parameter int unsigned            W_data_arf = 32,
  parameter int unsigned            DEPTH      = 4,
  parameter logic [W_data_arf-1:0]  RESET_PC   = '0,
  parameter int unsigned            W_opcode   = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [W_data_arf-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [W_data_arf-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [W_data_arf-1:0] redirect_pc,
  input  logic                  stall,
  output logic [W_data_arf-1:0] val_arh_instruct_odf,
  output logic [W_data_arf-1:0] val_arh_pc_odf,
  output logic [W_data_arf-1:0] val_arh_spec_odf,
  output logic                  valid_arh_odf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [W_opcode-1:0]   OP_JAL = W_opcode'(7'b1101111);
  // addi x0,x0,0: an all-zero word would decode as a load downstream
  localparam logic [W_data_arf-1:0] BUBBLE = W_data_arf'(32'h0000_0013);

  typedef struct packed {
    logic [W_data_arf-1:0] instr;
    logic [W_data_arf-1:0] pc;
    logic [W_data_arf-1:0] spec;
  } entry_t;

  entry_t                fifo_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [W_data_arf-1:0] fetch_pc;
  logic [W_data_arf-1:0] resp_pc;

  logic [W_opcode-1:0]   opcode;
  logic [W_data_arf-1:0] imm_c;
  logic [W_data_arf-1:0] spec_c;
  logic [CW-1:0]         out_next;
  logic                  empty;
  logic                  discard;
  logic                  accept;
  logic                  jal_hit;
  logic                  cap_ok;
  logic                  issue;
  logic                  pop;

  // Response classification, JAL prediction and request/pop qualification
  always_comb begin
    opcode  = imem_resp_data[W_opcode-1:0];
    imm_c   = {{(W_data_arf-21){imem_resp_data[W_data_arf-1]}}, imem_resp_data[W_data_arf-1],
               imem_resp_data[19:12], imem_resp_data[20], imem_resp_data[30:21], 1'b0};
    empty   = (count == '0);
    discard = imem_resp_valid && ((drop_cnt != '0) || redirect_valid);
    accept  = imem_resp_valid && !discard;
    jal_hit = accept && (opcode == OP_JAL);
    spec_c  = (opcode == OP_JAL) ? resp_pc + imm_c : resp_pc + W_data_arf'(4);
    cap_ok  = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    imem_req_valid = !reset && !redirect_valid && !jal_hit && cap_ok;
    imem_req_addr  = fetch_pc;
    issue    = imem_req_valid && imem_req_ready;
    pop      = !stall && !empty && !redirect_valid;
    out_next = outstanding + CW'(issue) - CW'(imem_resp_valid);
  end

  // Head presentation; bubble when nothing is buffered
  always_comb begin
    val_arh_instruct_odf = BUBBLE;
    val_arh_pc_odf       = '0;
    val_arh_spec_odf     = '0;
    valid_arh_odf        = 1'b0;
    if (!empty) begin
      val_arh_instruct_odf = fifo_mem[rd_ptr].instr;
      val_arh_pc_odf       = fifo_mem[rd_ptr].pc;
      val_arh_spec_odf     = fifo_mem[rd_ptr].spec;
      valid_arh_odf        = 1'b1;
    end
  end

  // Control state: redirect beats JAL self-redirect beats plain issue/accept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= out_next;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (jal_hit) begin
          fetch_pc <= spec_c;
          resp_pc  <= spec_c;
          drop_cnt <= out_next;
        end else begin
          if (issue)  fetch_pc <= fetch_pc + W_data_arf'(4);
          if (accept) resp_pc  <= resp_pc + W_data_arf'(4);
          if (discard && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
        if (accept) wr_ptr <= wr_ptr + PW'(1);
        if (pop)    rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(accept) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset; it is only observed while count is non-zero
  always_ff @(posedge clock) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= '{instr: imem_resp_data, pc: resp_pc, spec: spec_c};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory responder plus an architectural program-flow
// model that predicts every instruction decode should see.
module tb_fetch_queue;

  localparam int unsigned W        = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] val_arh_instruct_odf, val_arh_pc_odf, val_arh_spec_odf;
  logic        valid_arh_odf;

  fetch_queue #(.W_data_arf(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .W_opcode(7)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .val_arh_instruct_odf(val_arh_instruct_odf), .val_arh_pc_odf(val_arh_pc_odf),
    .val_arh_spec_odf(val_arh_spec_odf), .valid_arh_odf(valid_arh_odf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_total, n_fail;
  logic [31:0] prog_w   [64];
  bit          prog_j   [64];
  int          prog_off [64];
  logic [31:0] pend_a [$];
  int unsigned pend_t [$];
  logic [31:0] iss_log [$];
  int unsigned cyc, rdy_pct, rsp_pct, lat_v;
  int          n_issue, n_pop;
  bit          stall_v, redir_v, redir_on_jal, jal_redir_fired, nodrop, first_pend;
  logic [31:0] redir_pc_v, exp_pc, first_exp, saved_pc;

  function automatic logic [31:0] jal_enc(input int off);
    logic [20:0] imm;
    imm = 21'(off);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6F};
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return prog_w[a[7:2]];
  endfunction

  // Architectural successor: JAL jumps by its offset, everything else falls through
  function automatic logic [31:0] next_pc(input logic [31:0] a);
    return prog_j[a[7:2]] ? a + 32'(prog_off[a[7:2]]) : a + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic prog_nops();
    for (int i = 0; i < 64; i++) begin
      prog_w[i] = NOP; prog_j[i] = 1'b0; prog_off[i] = 0;
    end
  endtask

  // One clock: drive inputs after the falling edge, observe, then let the rising edge pass
  task automatic step();
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if (pend_a.size() > 0 && cyc >= pend_t[0] && $urandom_range(99) < rsp_pct) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_at(pend_a[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    stall = stall_v; redirect_valid = redir_v; redirect_pc = redir_pc_v;
    if (redir_on_jal && imem_resp_valid && pend_a[0] == 32'h8 && prog_j[2]) begin
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      redir_on_jal = 1'b0; jal_redir_fired = 1'b1;
    end
    #1;
    if (!valid_arh_odf) begin
      chk("bubble_instr", val_arh_instruct_odf, NOP);
      chk("bubble_pc", val_arh_pc_odf, 32'h0);
      chk("bubble_spec", val_arh_spec_odf, 32'h0);
    end else begin
      chk("head_pc", val_arh_pc_odf, exp_pc);
      chk("head_instr", val_arh_instruct_odf, word_at(exp_pc));
      chk("head_spec", val_arh_spec_odf, next_pc(exp_pc));
      if (!stall && !redirect_valid) begin
        exp_pc = next_pc(exp_pc);
        n_pop++;
      end
    end
    if (redirect_valid) chk("req_on_redirect", 32'(imem_req_valid), 32'h0);
    if (first_pend && imem_req_valid) begin
      chk("first_addr", imem_req_addr, first_exp);
      first_pend = 1'b0;
    end
    if (imem_req_valid) chk("addr_align", 32'(imem_req_addr[1:0]), 32'h0);
    if (redirect_valid) begin
      exp_pc = redirect_pc; first_pend = 1'b1; first_exp = redirect_pc;
    end
    if (imem_req_valid && imem_req_ready) begin
      pend_a.push_back(imem_req_addr); pend_t.push_back(cyc + lat_v);
      iss_log.push_back(imem_req_addr); n_issue++;
    end
    if (imem_resp_valid) begin
      void'(pend_a.pop_front()); void'(pend_t.pop_front());
    end
    if (nodrop) chk("cap", 32'((n_issue - n_pop) <= int'(DEPTH)), 32'h1);
    @(posedge clock); cyc++; @(negedge clock);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock
  task automatic do_reset();
    #2 reset = 1'b1;
    imem_resp_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("rst_instr", val_arh_instruct_odf, NOP);
    chk("rst_pc", val_arh_pc_odf, 32'h0);
    chk("rst_spec", val_arh_spec_odf, 32'h0);
    chk("rst_valid", 32'(valid_arh_odf), 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    pend_a.delete(); pend_t.delete(); iss_log.delete();
    exp_pc = RESET_PC; n_issue = 0; n_pop = 0;
    stall_v = 1'b0; redir_v = 1'b0; redir_pc_v = 32'h0;
    @(negedge clock);
    reset = 1'b0; first_pend = 1'b1; first_exp = RESET_PC;
  endtask

  initial begin
    n_total = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    stall_v = 1'b0; redir_v = 1'b0; redir_pc_v = 32'h0; redir_on_jal = 1'b0;
    jal_redir_fired = 1'b0; nodrop = 1'b0; first_pend = 1'b0; first_exp = 32'h0;
    exp_pc = RESET_PC; n_issue = 0; n_pop = 0; saved_pc = 32'h0;
    rdy_pct = 100; rsp_pct = 100; lat_v = 1;
    prog_nops();
    @(negedge clock);

    // Straight-line NOPs, always-ready single-cycle memory
    do_reset();
    nodrop = 1'b1;
    steps(8);
    chk("s1_issue_count", 32'(iss_log.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) chk("s1_issue_addr", iss_log[i], 32'(i * 4));
    chk("s1_pops", 32'(n_pop >= 3), 32'h1);

    // Decode stalls: buffered + in-flight saturates at DEPTH and the head holds
    saved_pc = exp_pc;
    stall_v = 1'b1; rdy_pct = 40;
    steps(20);
    rdy_pct = 100;
    steps(6);
    chk("s2_req_dropped", 32'(imem_req_valid), 32'h0);
    chk("s2_saturated", 32'(n_issue - n_pop), 32'(DEPTH));
    chk("s2_head_valid", 32'(valid_arh_odf), 32'h1);
    chk("s2_head_pc", val_arh_pc_odf, saved_pc);
    stall_v = 1'b0;
    steps(10);
    nodrop = 1'b0;

    // Mid-stream reset, then JAL +16 at 0x8 with two-cycle memory
    do_reset();
    prog_w[2] = jal_enc(16); prog_j[2] = 1'b1; prog_off[2] = 16;
    lat_v = 2;
    steps(12);
    chk("s3_issue_count", 32'(iss_log.size() >= 5), 32'h1);
    for (int i = 0; i < 4; i++) chk("s3_issue_addr", iss_log[i], 32'(i * 4));
    chk("s3_jal_target", iss_log[4], 32'h18);

    // Execute redirect while fetches are buffered and in flight
    lat_v = 3; stall_v = 1'b1;
    steps(4);
    redir_v = 1'b1; redir_pc_v = 32'h100;
    step();
    redir_v = 1'b0;
    chk("s4_flush_valid", 32'(valid_arh_odf), 32'h0);
    chk("s4_flush_instr", val_arh_instruct_odf, NOP);
    stall_v = 1'b0;
    steps(15);

    // Redirect coinciding with the JAL response at 0x8
    lat_v = 1;
    redir_v = 1'b1; redir_pc_v = 32'h0;
    step();
    redir_v = 1'b0; redir_on_jal = 1'b1;
    for (int i = 0; i < 30 && !jal_redir_fired; i++) step();
    chk("s5_collision_seen", 32'(jal_redir_fired), 32'h1);
    redir_on_jal = 1'b0;
    steps(10);

    // Randomised program, memory timing, stalls and redirects
    do_reset();
    for (int i = 0; i < 64; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(9) < 3) begin
        prog_off[i] = (int'($urandom_range(31)) - 16) * 4;
        prog_j[i] = 1'b1;
        prog_w[i] = jal_enc(prog_off[i]);
      end else begin
        prog_off[i] = 0;
        prog_j[i] = 1'b0;
        case ($urandom_range(3))
          0: prog_w[i] = {r[31:7], 7'h13};
          1: prog_w[i] = {r[31:7], 7'h33};
          2: prog_w[i] = {r[31:7], 7'h63};
          default: prog_w[i] = {r[31:7], 7'h03};
        endcase
      end
    end
    rdy_pct = 70; rsp_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      lat_v      = $urandom_range(3, 1);
      stall_v    = ($urandom_range(3) == 0);
      redir_v    = ($urandom_range(39) == 0);
      redir_pc_v = {24'h0, 6'($urandom_range(63)), 2'b00};
      step();
    end
    chk("rand_progress", 32'(n_pop >= 100), 32'h1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
